// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - two-product vending sequencer: credit, stock, motor handshake, change return
module vend_controller #(
   parameter int PRICE_A       = 3,
   parameter int PRICE_B       = 4,
   parameter int MAX_CREDIT    = 9,
   parameter int CREDIT_W      = 4,
   parameter int STOCK_W       = 4,
   parameter int INIT_STOCK    = 8,
   parameter int MOTOR_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_1,
   input  logic                coin_2,
   input  logic                sel_a,
   input  logic                sel_b,
   input  logic                cancel,
   input  logic                refill,
   input  logic                motor_done,
   output logic                motor_req,
   output logic                motor_sel,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic                sel_err,
   output logic [CREDIT_W-1:0] credit,
   output logic                empty_a,
   output logic                empty_b,
   output logic                busy,
   output logic                fault
);
   localparam int TW = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;
   localparam int XW = CREDIT_W + 2;
   localparam logic [XW-1:0]      PA     = XW'(PRICE_A);
   localparam logic [XW-1:0]      PB     = XW'(PRICE_B);
   localparam logic [XW-1:0]      MAXC   = XW'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);
   localparam logic [TW-1:0]      TLAST  = TW'(MOTOR_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   state_t               state, state_n;
   logic [STOCK_W-1:0]   stock_a, stock_b, stock_a_n, stock_b_n, eff_a, eff_b;
   logic [TW-1:0]        timer, timer_n;
   logic [XW-1:0]        cred_x, coin_v, sel_price, vend_price, refund;
   logic [CREDIT_W-1:0]  cred_n;
   logic                 motor_req_n, motor_sel_n, change_n, reject_n, sel_err_n, fault_n;
   logic                 coin_blocked, sel_bad;

   always_comb begin
      state_n      = state;
      cred_x       = XW'(credit);
      cred_n       = credit;
      stock_a_n    = stock_a;
      stock_b_n    = stock_b;
      timer_n      = timer;
      motor_req_n  = motor_req;
      motor_sel_n  = motor_sel;
      fault_n      = fault;
      change_n     = 1'b0;
      reject_n     = 1'b0;
      sel_err_n    = 1'b0;
      coin_blocked = 1'b1;
      coin_v       = XW'({coin_2, coin_1});
      // a refill in the same cycle as a select is seen by that select
      eff_a        = refill ? INIT_S : stock_a;
      eff_b        = refill ? INIT_S : stock_b;
      sel_price    = sel_a ? PA : PB;
      sel_bad      = sel_a ? (eff_a == '0) : (eff_b == '0);
      vend_price   = motor_sel ? PB : PA;
      refund       = cred_x + vend_price;

      case (state)
         IDLE: begin
            stock_a_n = eff_a;
            stock_b_n = eff_b;
            if (cancel && credit != '0) begin
               state_n = CHANGE;
            end else if (sel_a || sel_b) begin
               if (sel_bad || cred_x < sel_price) begin
                  sel_err_n    = 1'b1;
                  coin_blocked = 1'b0;
               end else begin
                  cred_n      = CREDIT_W'(cred_x - sel_price);
                  if (sel_a) stock_a_n = eff_a - STOCK_W'(1);
                  else       stock_b_n = eff_b - STOCK_W'(1);
                  motor_sel_n = ~sel_a;
                  motor_req_n = 1'b1;
                  timer_n     = '0;
                  state_n     = VEND;
               end
            end else begin
               coin_blocked = 1'b0;
            end
         end
         VEND: begin
            if (motor_done) begin
               motor_req_n = 1'b0;
               state_n     = (credit != '0) ? CHANGE : IDLE;
            end else if (timer == TLAST) begin
               fault_n     = 1'b1;
               motor_req_n = 1'b0;
               cred_n      = CREDIT_W'((refund > MAXC) ? MAXC : refund);
               state_n     = CHANGE;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         CHANGE: begin
            if (credit != '0) begin
               change_n = 1'b1;
               cred_n   = credit - CREDIT_W'(1);
            end
            if (credit <= CREDIT_W'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (coin_v != '0) begin
         if (!coin_blocked && (cred_x + coin_v) <= MAXC) cred_n = CREDIT_W'(cred_x + coin_v);
         else                                            reject_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         credit       <= '0;
         stock_a      <= INIT_S;
         stock_b      <= INIT_S;
         timer        <= '0;
         motor_req    <= 1'b0;
         motor_sel    <= 1'b0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         sel_err      <= 1'b0;
         fault        <= 1'b0;
         busy         <= 1'b0;
         empty_a      <= (INIT_S == '0);
         empty_b      <= (INIT_S == '0);
      end else begin
         state        <= state_n;
         credit       <= cred_n;
         stock_a      <= stock_a_n;
         stock_b      <= stock_b_n;
         timer        <= timer_n;
         motor_req    <= motor_req_n;
         motor_sel    <= motor_sel_n;
         change_pulse <= change_n;
         coin_reject  <= reject_n;
         sel_err      <= sel_err_n;
         fault        <= fault_n;
         busy         <= (state_n != IDLE);
         empty_a      <= (stock_a_n == '0);
         empty_b      <= (stock_b_n == '0);
      end
   end
endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed and randomized bench for vend_controller
module tb_vend_controller;
   localparam int PA = 3, PB = 4, MAXC = 9, INIT = 8, TMO = 16;

   logic       clk = 1'b0, reset = 1'b0;
   logic       coin_1 = 1'b0, coin_2 = 1'b0, sel_a = 1'b0, sel_b = 1'b0;
   logic       cancel = 1'b0, refill = 1'b0, motor_done = 1'b0;
   logic       motor_req, motor_sel, change_pulse, coin_reject, sel_err;
   logic [3:0] credit;
   logic       empty_a, empty_b, busy, fault;

   int n_cmp = 0, n_bad = 0;
   int md_delay = 2, md_cnt = 0;
   int m_cr, m_sa, m_sb, m_phase, m_vc, m_req, m_sel, m_pulse, m_rej, m_serr, m_fault;

   vend_controller #(.PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAXC), .CREDIT_W(4),
                     .STOCK_W(4), .INIT_STOCK(INIT), .MOTOR_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .coin_1(coin_1), .coin_2(coin_2), .sel_a(sel_a),
      .sel_b(sel_b), .cancel(cancel), .refill(refill), .motor_done(motor_done),
      .motor_req(motor_req), .motor_sel(motor_sel), .change_pulse(change_pulse),
      .coin_reject(coin_reject), .sel_err(sel_err), .credit(credit),
      .empty_a(empty_a), .empty_b(empty_b), .busy(busy), .fault(fault));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cr = 0; m_sa = INIT; m_sb = INIT; m_phase = 0; m_vc = 0; m_req = 0;
      m_sel = 0; m_pulse = 0; m_rej = 0; m_serr = 0; m_fault = 0;
   endtask

   // phase: 0 waiting for customer, 1 motor running, 2 paying out change
   task automatic model_step();
      int  v, p, stk, back;
      bit  blocked;
      v = int'(coin_1) + 2 * int'(coin_2);
      blocked = 1'b1;
      m_pulse = 0; m_rej = 0; m_serr = 0;
      if (m_phase == 0) begin
         if (refill) begin m_sa = INIT; m_sb = INIT; end
         if (cancel && m_cr > 0) m_phase = 2;
         else if (sel_a || sel_b) begin
            p   = sel_a ? PA : PB;
            stk = sel_a ? m_sa : m_sb;
            if (stk == 0 || m_cr < p) begin
               m_serr = 1; blocked = 1'b0;
            end else begin
               m_cr -= p;
               if (sel_a) m_sa--; else m_sb--;
               m_sel = sel_a ? 0 : 1; m_req = 1; m_vc = 0; m_phase = 1;
            end
         end else blocked = 1'b0;
      end else if (m_phase == 1) begin
         m_vc++;
         if (motor_done) begin
            m_req = 0; m_phase = (m_cr > 0) ? 2 : 0;
         end else if (m_vc == TMO) begin
            back = m_cr + (m_sel ? PB : PA);
            m_cr = (back > MAXC) ? MAXC : back;
            m_fault = 1; m_req = 0; m_phase = 2;
         end
      end else begin
         m_pulse = 1; m_cr--;
         if (m_cr == 0) m_phase = 0;
      end
      if (v > 0) begin
         if (!blocked && m_cr + v <= MAXC) m_cr += v;
         else m_rej = 1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else begin
            model_step();
            #1;
            chk("credit", int'(credit), m_cr);
            chk("motor_req", int'(motor_req), m_req);
            chk("motor_sel", int'(motor_sel), m_sel);
            chk("change_pulse", int'(change_pulse), m_pulse);
            chk("coin_reject", int'(coin_reject), m_rej);
            chk("sel_err", int'(sel_err), m_serr);
            chk("empty_a", int'(empty_a), int'(m_sa == 0));
            chk("empty_b", int'(empty_b), int'(m_sb == 0));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("fault", int'(fault), m_fault);
         end
      end
   end

   // motor driver stand-in: completes md_delay cycles after the request appears
   initial forever begin
      @(negedge clk);
      if (!motor_req) begin md_cnt = 0; motor_done = 1'b0; end
      else begin md_cnt++; motor_done = (md_cnt >= md_delay); end
   end

   task automatic drive(input bit c1, input bit c2, input bit sa, input bit sb,
                        input bit cn, input bit rf);
      @(negedge clk);
      coin_1 = c1; coin_2 = c2; sel_a = sa; sel_b = sb; cancel = cn; refill = rf;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wait_idle(output int pulses);
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         idle();
         pulses += int'(change_pulse);
         if (!busy) break;
      end
      chk("idle_reached", int'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, k;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_empty_a", int'(empty_a), 0);
      chk("rst_motor_req", int'(motor_req), 0);
      @(negedge clk) reset = 1'b1;

      // three single coins then product A, exact credit
      md_delay = 4;
      repeat (3) drive(1, 0, 0, 0, 0, 0);
      chk("t1_credit", int'(credit), 3);
      drive(0, 0, 1, 0, 0, 0);
      chk("t1_req", int'(motor_req), 1);
      chk("t1_sel", int'(motor_sel), 0);
      chk("t1_credit_after", int'(credit), 0);
      wait_idle(p);
      chk("t1_pulses", p, 0);

      // product B with two units of change
      md_delay = 2;
      repeat (3) drive(0, 1, 0, 0, 0, 0);
      chk("t2_credit", int'(credit), 6);
      drive(0, 0, 0, 1, 0, 0);
      chk("t2_credit_after", int'(credit), 2);
      wait_idle(p);
      chk("t2_pulses", p, 2);

      // over-ceiling coin then full refund
      repeat (4) drive(0, 1, 0, 0, 0, 0);
      chk("t3_credit", int'(credit), 8);
      drive(0, 1, 0, 0, 0, 0);
      chk("t3_reject", int'(coin_reject), 1);
      chk("t3_credit_kept", int'(credit), 8);
      drive(0, 0, 0, 0, 1, 0);
      wait_idle(p);
      chk("t3_pulses", p, 8);

      // drain A, refused select, refill
      repeat (7) begin
         drive(1, 1, 0, 0, 0, 0);
         drive(0, 0, 1, 0, 0, 0);
         wait_idle(p);
      end
      chk("t4_empty_a", int'(empty_a), 1);
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      chk("t4_sel_err", int'(sel_err), 1);
      chk("t4_credit_kept", int'(credit), 3);
      drive(0, 0, 0, 0, 0, 1);
      chk("t4_refilled", int'(empty_a), 0);
      drive(0, 0, 0, 0, 1, 0);
      wait_idle(p);

      // motor never answers: timeout refunds the price
      md_delay = 1000;
      repeat (2) drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         idle();
         if (fault) begin k = i; break; end
      end
      chk("t5_fault_cycle", k, 16);
      wait_idle(p);
      chk("t5_pulses", p, 4);
      chk("t5_fault_sticky", int'(fault), 1);

      // same-cycle priorities
      md_delay = 2;
      repeat (2) drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      chk("t6_ab_sel", int'(motor_sel), 0);
      chk("t6_ab_credit", int'(credit), 1);
      wait_idle(p);
      chk("t6_ab_pulses", p, 1);
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0);
      chk("t6_cancel_no_req", int'(motor_req), 0);
      chk("t6_cancel_busy", int'(busy), 1);
      wait_idle(p);
      chk("t6_cancel_pulses", p, 3);
      repeat (3) drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      chk("t6_both_reject", int'(coin_reject), 1);
      chk("t6_both_credit", int'(credit), 7);
      drive(0, 0, 0, 0, 1, 0);
      wait_idle(p);

      // asynchronous reset while vending
      md_delay = 1000;
      drive(1, 1, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      idle();
      chk("t7_in_vend", int'(motor_req), 1);
      #3 reset = 1'b0;
      #1;
      chk("t7_rst_req", int'(motor_req), 0);
      chk("t7_rst_busy", int'(busy), 0);
      chk("t7_rst_fault", int'(fault), 0);
      chk("t7_rst_credit", int'(credit), 0);
      @(negedge clk) reset = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (!motor_req) md_delay = $urandom_range(1, 18);
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
         if (i % 700 == 699) begin
            #3 reset = 1'b0;
            #1;
            chk("rnd_rst_credit", int'(credit), 0);
            @(negedge clk) reset = 1'b1;
         end
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vend_controller.md
# vend_controller

Two-product vending sequencer that owns the credit register, per-product stock counters, dispense-motor handshake and unit-by-unit change return. It sits between the coin acceptor and selection buttons on one side and the dispense motor driver and change hopper on the other. It replaces the single-price `dispense`/`change` flags with a credit-based scheduler for multiple prices and quantities.

## Interface
- PRICE_A, 3: credit units for product A (1..MAX_CREDIT)
- PRICE_B, 4: credit units for product B (1..MAX_CREDIT)
- MAX_CREDIT, 9: credit ceiling; must be ≤ 2^CREDIT_W−1
- CREDIT_W, 4: credit register width
- STOCK_W, 4: stock counter width
- INIT_STOCK, 8: stock loaded at reset and on refill
- MOTOR_TIMEOUT, 16: cycles to wait for motor_done before a fault is declared

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- coin_1, coin_2  in  1  one-cycle pulses worth 1 and 2 credit units
- sel_a, sel_b  in  1  one-cycle product select pulses
- cancel  in  1  one-cycle pulse requesting refund of the credit
- refill  in  1  one-cycle pulse that reloads both stocks
- motor_done  in  1  motor driver completion, sampled while motor_req=1
- motor_req  out  1  dispense request, level, held until motor_done
- motor_sel  out  1  0=A, 1=B; valid while motor_req=1
- change_pulse  out  1  one cycle per credit unit returned
- coin_reject  out  1  one-cycle pulse: coin not accepted
- sel_err  out  1  one-cycle pulse: select refused
- credit  out  CREDIT_W  current credit
- empty_a, empty_b  out  1  stock counter == 0
- busy  out  1  state != IDLE
- fault  out  1  sticky motor timeout flag, cleared only by reset

## Operation
- All outputs are registered. Reset values: credit=0, stocks=INIT_STOCK, state=IDLE, and every 1-bit output 0 (empty_x=0 unless INIT_STOCK=0).
- States: IDLE, VEND, CHANGE.
- IDLE, coins:
  - Coin value v = coin_1 + 2·coin_2; both coins in the same cycle give v=3, accepted or rejected as a unit.
  - If credit+v ≤ MAX_CREDIT, add v to credit. Otherwise credit is unchanged and coin_reject is pulsed.
- IDLE, select:
  - sel_a wins over sel_b when both arrive in the same cycle.
  - The select is refused (sel_err pulse, no state change) if the chosen stock is 0 or credit < price.
  - Otherwise: credit −= price, stock −= 1, motor_sel is set, motor_req=1, go to VEND.
  - A coin arriving in the same cycle as an accepted select is rejected.
- IDLE, cancel:
  - Priority is cancel > select > coin.
  - If credit > 0, go to CHANGE; the same-cycle coin is rejected. If credit = 0, cancel does nothing.
- IDLE, refill: both stocks load INIT_STOCK. Refill is ignored in VEND and CHANGE.
- VEND:
  - motor_req is held. The timeout counter counts cycles in VEND.
  - When motor_done=1: motor_req goes to 0; go to CHANGE if credit > 0, else IDLE.
  - If the counter reaches MOTOR_TIMEOUT without motor_done: fault=1, motor_req goes to 0, credit += price of motor_sel (saturating at MAX_CREDIT). The stock is not restored. Go to CHANGE.
- CHANGE: each cycle change_pulse=1 and credit −= 1. When credit reaches 0, go to IDLE.
- Coins in VEND or CHANGE are rejected. sel and cancel in VEND or CHANGE are ignored silently (no sel_err).
- Stock never decrements below 0. Credit never exceeds MAX_CREDIT or drops below 0.

## Timing
- Coin at edge N: credit is updated at N+1; coin_reject is high during the cycle after N.
- Accepted select at edge N: motor_req, motor_sel, credit and stock are all updated after N.
- motor_done=1 at edge M: motor_req=0 after M. The first change_pulse is high in the cycle after M+1's state entry, i.e. the cycle following M+1.
- CHANGE with credit=k on entry: change_pulse is high for exactly k consecutive cycles, then busy=0.
- Timeout: fault rises at edge VEND_entry+MOTOR_TIMEOUT. motor_done arriving in that same cycle wins; no fault is raised.
- Asynchronous reset mid-VEND or mid-CHANGE: motor_req and change_pulse drop immediately and credit is lost.

## Test plan
- Insert coin_1 ×3 (credit 3), then sel_a -> motor_req=1, motor_sel=0, credit=0; motor_done after 4 cycles -> IDLE with no change_pulse, stock A=7.
- Insert coin_2 ×3 (credit 6), then sel_b -> credit 2; motor_done -> 2 consecutive change_pulse cycles, credit 0, busy=0.
- Insert credit 8, then coin_2 -> coin_reject pulse, credit stays 8. Then cancel -> 8 change_pulses.
- Drain stock A to 0 -> empty_a=1; next sel_a with credit 3 -> sel_err, credit 3 retained. refill -> empty_a=0, stock 8.
- sel_b with credit 4 and motor_done never asserted -> fault=1 at cycle 16, 4 change_pulses, stock B decremented, fault stays set.
- Same-cycle cases: sel_a+sel_b -> product A vended; cancel+sel_a -> refund with no vend; coin_1+coin_2 at credit 7 -> both rejected; reset asserted during VEND -> all outputs return to reset values immediately.
